// File: rtl/status_monitor_mc.sv
// status_monitor_mc
//   Per-channel saturating finished-task counters with masked clear. Every
//   counter that changes (or is cleared) is mirrored into status BRAM through
//   a single-outstanding WR_START/WR_DONE write port. Dirty channels are
//   served round-robin; updates that arrive while a write is in flight only
//   re-mark the channel dirty, so one later write carries the final value.
//
//   Optional feature macro: STATUS_IRQ_EN
//     adds parameter THRESH and outputs IRQ / IRQ_VEC (sticky per-channel
//     threshold-reached flags, cleared by a clear of that channel).
//
// Ports
//   ACLK       in   clock
//   ARESET     in   synchronous active-high reset
//   TASK_DONE  in   [NUM_CH] one-cycle increment pulse per channel
//   CLR_REQ    in   clear strobe
//   CLR_MASK   in   [NUM_CH] channels cleared when CLR_REQ=1
//   WR_START   out  write request, held until WR_DONE
//   WR_ADDR    out  [32] BRAM byte address of the channel word
//   WR_DATA    out  [64] {sat, 15'b0, ch[15:0], count[31:0]}
//   WR_DONE    in   one-cycle write completion
//   BUSY       out  write in ISSUE or WAIT
//   IRQ        out  (STATUS_IRQ_EN) registered OR of IRQ_VEC
//   IRQ_VEC    out  (STATUS_IRQ_EN) [NUM_CH] sticky threshold flags
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | port free; pick first dirty channel at/after rr pointer
// S_ISSUE | latch address/data of picked channel, raise WR_START
// S_WAIT  | hold request stable until WR_DONE, then advance rr pointer

module status_monitor_mc #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          ADDR_STRIDE = 8
`ifdef STATUS_IRQ_EN
    ,
    parameter logic [CNT_W-1:0] THRESH = CNT_W'(16)
`endif
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [NUM_CH-1:0] TASK_DONE,
    input  logic              CLR_REQ,
    input  logic [NUM_CH-1:0] CLR_MASK,
    output logic              WR_START,
    output logic [31:0]       WR_ADDR,
    output logic [63:0]       WR_DATA,
    input  logic              WR_DONE,
    output logic              BUSY
`ifdef STATUS_IRQ_EN
    ,
    output logic              IRQ,
    output logic [NUM_CH-1:0] IRQ_VEC
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] sat_q, sat_d;
    logic [NUM_CH-1:0] upd;
    logic [NUM_CH-1:0] dirty_q, dirty_d;
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   sel_q;

    logic              pick_found;
    logic [CH_W-1:0]   pick_ch;
    int                scan_idx;
    logic [CH_W-1:0]   scan_ch;

    logic              take_sel;
    logic              do_issue;
    logic              do_done;

    logic [31:0]       sel_cnt32;
    logic [31:0]       wr_addr_d;
    logic [63:0]       wr_data_d;

    // Counter update. Clear beats increment but keeps a same-cycle pulse.
    // upd marks any visible change, plus every clear even of a zero count.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            sat_d[i] = sat_q[i];
            upd[i]   = 1'b0;
            if (CLR_REQ && CLR_MASK[i]) begin
                cnt_d[i] = TASK_DONE[i] ? CNT_W'(1) : '0;
                sat_d[i] = 1'b0;
                upd[i]   = 1'b1;
            end else if (TASK_DONE[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sat_d[i] = 1'b1;
                    upd[i]   = ~sat_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    upd[i]   = 1'b1;
                end
            end
        end
    end

    // Round-robin pick: first dirty channel at or after rr_q, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        scan_idx   = 0;
        scan_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_CH) begin
                scan_idx = scan_idx - NUM_CH;
            end
            scan_ch = CH_W'(scan_idx);
            if (!pick_found && dirty_q[scan_ch]) begin
                pick_found = 1'b1;
                pick_ch    = scan_ch;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_found) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (WR_DONE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        take_sel = 1'b0;
        do_issue = 1'b0;
        do_done  = 1'b0;
        case (state_q)
            S_IDLE:  take_sel = pick_found;
            S_ISSUE: do_issue = 1'b1;
            S_WAIT:  do_done  = WR_DONE;
            default: ;
        endcase
        BUSY = (state_q != S_IDLE);
    end

    // A same-cycle update to the channel being issued keeps it dirty so the
    // newer value is guaranteed a later write.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            dirty_d[i] = dirty_q[i] | upd[i];
            if (do_issue && (sel_q == CH_W'(i)) && !upd[i]) begin
                dirty_d[i] = 1'b0;
            end
        end
    end

    // Write payload uses the post-update value of the current cycle.
    always_comb begin
        sel_cnt32              = '0;
        sel_cnt32[CNT_W-1:0]   = cnt_d[sel_q];
        wr_addr_d = BASE_ADDR + 32'(sel_q) * 32'(ADDR_STRIDE);
        wr_data_d = {sat_d[sel_q], 15'b0, 16'(sel_q), sel_cnt32};
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            sat_q    <= '0;
            dirty_q  <= '0;
            rr_q     <= '0;
            sel_q    <= '0;
            WR_START <= 1'b0;
            WR_ADDR  <= '0;
            WR_DATA  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sat_q   <= sat_d;
            dirty_q <= dirty_d;
            if (take_sel) begin
                sel_q <= pick_ch;
            end
            if (do_issue) begin
                WR_START <= 1'b1;
                WR_ADDR  <= wr_addr_d;
                WR_DATA  <= wr_data_d;
            end
            if (do_done) begin
                WR_START <= 1'b0;
                rr_q     <= (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + CH_W'(1);
            end
        end
    end

`ifdef STATUS_IRQ_EN
    logic [NUM_CH-1:0] irq_vec_d;

    // A clear drops the flag unless the post-clear count itself hits THRESH.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            irq_vec_d[i] = IRQ_VEC[i];
            if (CLR_REQ && CLR_MASK[i]) begin
                irq_vec_d[i] = (cnt_d[i] == THRESH);
            end else if ((cnt_d[i] == THRESH) && (cnt_q[i] != THRESH)) begin
                irq_vec_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            IRQ_VEC <= '0;
            IRQ     <= 1'b0;
        end else begin
            IRQ_VEC <= irq_vec_d;
            IRQ     <= |IRQ_VEC;
        end
    end
`endif

endmodule

// File: tb/tb_status_monitor_mc.sv
module tb_status_monitor_mc;

    localparam int          NUM_CH = 4;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] BASE   = 32'h0;
    localparam int          STRIDE = 8;
    localparam int          MAXC   = (1 << CNT_W) - 1;

    logic              ACLK      = 1'b0;
    logic              ARESET    = 1'b1;
    logic [NUM_CH-1:0] TASK_DONE = '0;
    logic              CLR_REQ   = 1'b0;
    logic [NUM_CH-1:0] CLR_MASK  = '0;
    logic              WR_DONE   = 1'b0;
    logic              WR_START;
    logic [31:0]       WR_ADDR;
    logic [63:0]       WR_DATA;
    logic              BUSY;
`ifdef STATUS_IRQ_EN
    logic              IRQ;
    logic [NUM_CH-1:0] IRQ_VEC;
`endif

    status_monitor_mc #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .TASK_DONE(TASK_DONE),
        .CLR_REQ(CLR_REQ), .CLR_MASK(CLR_MASK),
        .WR_START(WR_START), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .WR_DONE(WR_DONE), .BUSY(BUSY)
`ifdef STATUS_IRQ_EN
        , .IRQ(IRQ), .IRQ_VEC(IRQ_VEC)
`endif
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    // Reference model: counts, dirty set, and write-port occupancy
    // (m_port: 0 free, 1 channel picked, 2 request outstanding).
    int                m_cnt [NUM_CH];
    bit                m_sat [NUM_CH];
    logic [NUM_CH-1:0] m_dirty;
    int                m_rr, m_port, m_ch;

    wr_t exp_q[$];
    wr_t wr_log[$];

    int errors = 0;
    int checks = 0;
    int done_lat = 2;
    int wcnt = 0;
    bit spur_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0;
            m_sat[i] = 1'b0;
        end
        m_dirty = '0;
        m_rr = 0;
        m_port = 0;
        m_ch = 0;
        exp_q.delete();
    endtask

    function automatic wr_t exp_of(input int ch);
        wr_t w;
        w.addr = BASE + 32'(ch * STRIDE);
        w.data = {m_sat[ch], 15'b0, 16'(ch), 32'(m_cnt[ch])};
        return w;
    endfunction

    // One clock: model consumes the inputs present at the edge, then the
    // BRAM responder drives WR_DONE for the next cycle.
    task automatic tick();
        logic [NUM_CH-1:0] upd;
        logic [NUM_CH-1:0] old_dirty;
        bit found;
        int idx;
        @(posedge ACLK);
        upd = '0;
        old_dirty = m_dirty;
        if (ARESET) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CLR_REQ && CLR_MASK[i]) begin
                    m_cnt[i] = TASK_DONE[i] ? 1 : 0;
                    m_sat[i] = 1'b0;
                    upd[i] = 1'b1;
                end else if (TASK_DONE[i]) begin
                    if (m_cnt[i] == MAXC) begin
                        upd[i] = !m_sat[i];
                        m_sat[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                        upd[i] = 1'b1;
                    end
                end
            end
            m_dirty = m_dirty | upd;
            if (m_port == 2) begin
                if (WR_DONE) begin
                    m_port = 0;
                    m_rr = (m_ch + 1) % NUM_CH;
                end
            end else if (m_port == 1) begin
                exp_q.push_back(exp_of(m_ch));
                if (!upd[m_ch]) m_dirty[m_ch] = 1'b0;
                m_port = 2;
            end else if (old_dirty != '0) begin
                found = 1'b0;
                for (int k = 0; k < NUM_CH; k++) begin
                    idx = (m_rr + k) % NUM_CH;
                    if (!found && old_dirty[idx]) begin
                        found = 1'b1;
                        m_ch = idx;
                    end
                end
                m_port = 1;
            end
        end
        #1;
        WR_DONE = 1'b0;
        if (WR_START) begin
            if (wcnt >= done_lat) begin
                WR_DONE = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (spur_en && $urandom_range(0, 9) == 0) WR_DONE = 1'b1;
        end
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        repeat (3) tick();
        ARESET = 1'b0;
        chk("rst_wr_start", 64'(WR_START), 64'd0);
        chk("rst_busy",     64'(BUSY),     64'd0);
        chk("rst_wr_addr",  64'(WR_ADDR),  64'd0);
        chk("rst_wr_data",  WR_DATA,       64'd0);
    endtask

    task automatic settle(input string name);
        int n = 0;
        while ((m_port != 0 || m_dirty != '0) && n < 1000) begin
            tick();
            n++;
        end
        chk({name, "_settle_timeout"}, 64'(n >= 1000), 64'd0);
        repeat (3) tick();
        chk({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every cycle compare the port against the model's occupancy;
    // on each new request pop the expected write and hold it through WAIT.
    initial begin
        logic prev_start = 1'b0;
        wr_t  cur;
        cur = '0;
        forever begin
            @(negedge ACLK);
            chk("wr_start_state", 64'(WR_START), 64'(m_port == 2));
            chk("busy_state",     64'(BUSY),     64'(m_port != 0));
            if (WR_START && !prev_start) begin
                wr_log.push_back({WR_ADDR, WR_DATA});
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_write actual_addr=%h actual_data=%h required=none",
                             WR_ADDR, WR_DATA);
                end else begin
                    cur = exp_q.pop_front();
                    chk("wr_addr", 64'(WR_ADDR), 64'(cur.addr));
                    chk("wr_data", WR_DATA, cur.data);
                end
            end else if (WR_START) begin
                chk("wr_addr_hold", 64'(WR_ADDR), 64'(cur.addr));
                chk("wr_data_hold", WR_DATA, cur.data);
            end
            prev_start = WR_START;
        end
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit f0, f2;
        int g;
        model_reset();
        do_reset();

        // Idle after reset: monitor checks WR_START low every cycle.
        repeat (20) tick();
        chk("idle_no_writes", 64'(wr_log.size()), 64'd0);

        // Three spaced pulses on ch2.
        done_lat = 2;
        for (int p = 0; p < 3; p++) begin
            TASK_DONE = 4'b0100;
            tick();
            TASK_DONE = '0;
            repeat (9) tick();
        end
        settle("ch2_pulses");
        chk("ch2_nwrites", 64'(wr_log.size()), 64'd3);
        for (int p = 0; p < 3 && p < wr_log.size(); p++) begin
            chk("ch2_addr", 64'(wr_log[p].addr), 64'h10);
            chk("ch2_data", wr_log[p].data, 64'h0000_0002_0000_0000 + 64'(p + 1));
        end

        // All channels at once: round-robin order ch0..ch3.
        do_reset();
        wr_log.delete();
        TASK_DONE = '1;
        tick();
        TASK_DONE = '0;
        settle("all_ch");
        chk("all_nwrites", 64'(wr_log.size()), 64'd4);
        for (int c = 0; c < 4 && c < wr_log.size(); c++) begin
            chk("all_addr", 64'(wr_log[c].addr), 64'(c * 8));
            chk("all_data", wr_log[c].data, {16'h0, 16'(c), 32'd1});
        end

        // Slow completion with coalesced updates on ch1.
        do_reset();
        wr_log.delete();
        done_lat = 50;
        TASK_DONE = 4'b0010;
        tick();
        TASK_DONE = '0;
        repeat (3) tick();
        for (int p = 0; p < 5; p++) begin
            TASK_DONE = 4'b0010;
            tick();
            TASK_DONE = '0;
            tick();
        end
        settle("coalesce");
        chk("coal_nwrites", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() == 2) begin
            chk("coal_first",  wr_log[0].data, 64'h0000_0001_0000_0001);
            chk("coal_second", wr_log[1].data, 64'h0000_0001_0000_0006);
            chk("coal_addr",   64'(wr_log[1].addr), 64'h8);
        end

        // Saturation with a 4-bit counter.
        do_reset();
        wr_log.delete();
        done_lat = 2;
        TASK_DONE = 4'b0001;
        repeat (17) tick();
        TASK_DONE = '0;
        settle("sat");
        chk("sat_final", wr_log[$].data, 64'h8000_0000_0000_000F);

        // Masked clear with a same-cycle increment on a cleared channel.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            TASK_DONE = {(k < 1), 1'b1, 1'b0, (k < 3)};
            tick();
        end
        TASK_DONE = '0;
        settle("clr_setup");
        wr_log.delete();
        CLR_REQ = 1'b1;
        CLR_MASK = 4'b0101;
        TASK_DONE = 4'b0100;
        tick();
        CLR_REQ = 1'b0;
        CLR_MASK = '0;
        TASK_DONE = '0;
        settle("clr");
        f0 = 1'b0;
        f2 = 1'b0;
        foreach (wr_log[j]) begin
            if (wr_log[j] == {32'h0, 64'h0}) f0 = 1'b1;
            if (wr_log[j] == {32'h10, 64'h0000_0002_0000_0001}) f2 = 1'b1;
        end
        chk("clr_nwrites", 64'(wr_log.size()), 64'd2);
        chk("clr_ch0_zero", 64'(f0), 64'd1);
        chk("clr_ch2_one",  64'(f2), 64'd1);

        // Clearing an already-zero channel still produces a write.
        wr_log.delete();
        CLR_REQ = 1'b1;
        CLR_MASK = 4'b0010;
        tick();
        CLR_REQ = 1'b0;
        CLR_MASK = '0;
        settle("clr_zero");
        chk("clr_zero_nwrites", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() == 1) begin
            chk("clr_zero_entry", 64'(wr_log[0].addr), 64'h8);
            chk("clr_zero_data", wr_log[0].data, 64'h0000_0001_0000_0000);
        end

        // Randomised traffic with spurious completions and a reset in WAIT.
        spur_en = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            TASK_DONE = NUM_CH'($urandom) & NUM_CH'($urandom);
            CLR_REQ = ($urandom_range(0, 19) == 0);
            CLR_MASK = NUM_CH'($urandom);
            if (wcnt == 0) done_lat = $urandom_range(0, 6);
            tick();
            if (n == 1200) begin
                CLR_REQ = 1'b0;
                done_lat = 40;
                g = 0;
                while (!WR_START && g < 50) begin
                    TASK_DONE = 4'b0001;
                    tick();
                    g++;
                end
                TASK_DONE = '0;
                chk("reset_in_wait_pending", 64'(WR_START), 64'd1);
                do_reset();
                WR_DONE = 1'b1;
                tick();
                repeat (3) tick();
                chk("late_done_ignored", 64'(BUSY), 64'd0);
            end
        end
        TASK_DONE = '0;
        CLR_REQ = 1'b0;
        CLR_MASK = '0;
        spur_en = 1'b0;
        settle("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/status_monitor_mc.md
Name: status_monitor_mc

Overview:
- Multi-channel successor to the single-counter task status monitor.
- Keeps a saturating finished-task counter per channel and supports a per-channel masked clear.
- Mirrors each changed counter into status BRAM through the WR_START/WR_DONE write port, one outstanding write at a time, with round-robin channel selection.
- Sits between the task-completion sources and the BRAM write master; the host reads the counts from BRAM.

Parameters:
- NUM_CH, 4: number of channels, 1..16.
- CNT_W, 8: counter width, 1..32.
- BASE_ADDR, 32'h0: BRAM address of channel 0.
- ADDR_STRIDE, 8: byte distance between channel words.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; synchronous, active-high.
- TASK_DONE  in  NUM_CH  per-channel one-cycle increment pulses.
- CLR_REQ  in  1  clear strobe; also serves as the clear-task-count interrupt.
- CLR_MASK  in  NUM_CH  channels cleared when CLR_REQ=1.
- WR_START  out  1  write request; held high until WR_DONE.
- WR_ADDR  out  32  write address.
- WR_DATA  out  64  write data.
- WR_DONE  in  1  one-cycle write completion.
- BUSY  out  1  high in ISSUE or WAIT state.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - All counters, dirty bits, saturation flags and the round-robin pointer go to 0.
  - FSM goes to IDLE.
  - WR_START, WR_ADDR, WR_DATA and BUSY go to 0.
  - Reset during WAIT abandons the write. Any late WR_DONE after reset is ignored.
- Counter update per channel, per cycle, in priority order:
  - CLR_REQ & CLR_MASK[i]: count := TASK_DONE[i] (a same-cycle increment is kept, so the count becomes 1); sat := 0.
  - Otherwise TASK_DONE[i]: count := count+1. At all-ones the count holds and sat := 1.
  - Dirty[i] is set whenever count or sat changes, and also on any clear, even when the count was already 0.
- FSM states:
  - IDLE: if any dirty bit is set, go to ISSUE. The selected channel is the first dirty channel at or after the RR pointer, wrapping modulo NUM_CH.
  - ISSUE (1 cycle):
    - Latch WR_ADDR = BASE_ADDR + ch*ADDR_STRIDE (32-bit wrap).
    - Latch WR_DATA = {sat, 15'b0, 16'(ch), 32'(count)} from the current-cycle post-update value.
    - Set WR_START=1 and clear dirty[ch]. If an update to ch lands in this same cycle, dirty[ch] stays set.
    - Go to WAIT.
  - WAIT:
    - WR_START, WR_ADDR and WR_DATA hold stable.
    - On WR_DONE: WR_START := 0, RR pointer := ch+1 (wrapping), go to IDLE.
- Latency:
  - First WR_START rises 2 cycles after the update edge (IDLE detect, then ISSUE).
  - Minimum spacing between writes is 3 cycles plus BRAM latency.
- Coalescing:
  - Increments during WAIT only set dirty. One later write carries the final value.
  - Writes are never lost; the last value written always equals the current count once the block is quiescent.
- WR_DONE outside WAIT is ignored.
- The write port is never released without WR_DONE, so there is no timeout.
- BUSY = (state != IDLE).

Optional Feature:
- Macro STATUS_IRQ_EN adds:
  - Parameter THRESH (default 8'd16).
  - Outputs IRQ (1 bit) and IRQ_VEC (NUM_CH bits).
- With the macro defined:
  - IRQ_VEC[i] is set sticky on the cycle count[i] transitions to ==THRESH.
  - IRQ_VEC[i] is cleared by a clear of channel i. A same-cycle clear wins unless the post-clear count equals THRESH.
  - IRQ = |IRQ_VEC, registered.
  - Reset value of both outputs is 0.
- Without the macro: no threshold logic, and the ports are absent.

Test Plan:
- Reset then idle, NUM_CH=4 -> all outputs 0, no WR_START for 20 cycles.
- 3 pulses on TASK_DONE[2] spaced 10 cycles, WR_DONE 2 cycles after WR_START -> three writes to addr 0x10 with data 1, 2, 3 and bits[47:32]=2.
- TASK_DONE=4'b1111 for one cycle -> writes in order ch0, ch1, ch2, ch3, each data count 1, WR_START held until each WR_DONE.
- WR_DONE delayed 50 cycles while ch1 gets 5 more pulses -> exactly one extra write of count 6 after the first completes.
- CNT_W=4, 17 pulses on ch0 -> final write data 0x8000_0000_0000_000F (sat=1, count=15).
- Counts {3,0,7,1}, then CLR_REQ with CLR_MASK=4'b0101 plus a same-cycle TASK_DONE[2] -> ch0 written 0, ch2 written 1, ch1 and ch3 unchanged; with STATUS_IRQ_EN and THRESH=7, IRQ_VEC[2] clears.
